// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer tone scheduler: state encoding,
// field widths and the note ROM word layout {half_period, duration}.
package buzzer_pkg;

    localparam int HP_W  = 16;
    localparam int DUR_W = 16;
    localparam int ROM_W = HP_W + DUR_W;

    localparam int HP_MSB  = 31;
    localparam int HP_LSB  = 16;
    localparam int DUR_MSB = 15;
    localparam int DUR_LSB = 0;

    localparam int DEF_TICK_DIV = 12000;
    localparam int DEF_NOTES    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_BEEP
    } state_e;

    function automatic logic [HP_W-1:0] rom_hp(input logic [ROM_W-1:0] word);
        return word[HP_MSB:HP_LSB];
    endfunction

    function automatic logic [DUR_W-1:0] rom_dur(input logic [ROM_W-1:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a
// duration tick. It never restarts on scheduler state changes.
module ms_tick_gen
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
)(
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// Drives the buzzer half-period from a melody note ROM and lets a one-shot key
// beep preempt the melody, which then resumes the interrupted note.
//
//   state | meaning
//   IDLE  | silent; accepts a beep or a melody start
//   FETCH | rom_addr = idx presented to the note ROM
//   LOAD  | rom_data captured: end marker or start of a note
//   PLAY  | note sounding, rem counts ticks down
//   BEEP  | beep sounding; a paused melody resumes afterwards
module tone_scheduler
    import buzzer_pkg::*;
#(
    parameter  int TICK_DIV = DEF_TICK_DIV,
    parameter  int NOTES    = DEF_NOTES,
    localparam int ADDR_W   = $clog2(NOTES)
)(
    input  logic              hwclk_i,
    input  logic              rst_i,
    input  logic              melody_start_i,
    input  logic              melody_stop_i,
    input  logic              beep_req_i,
    input  logic [HP_W-1:0]   beep_hp_i,
    input  logic [DUR_W-1:0]  beep_ticks_i,
    output logic              beep_ack_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [ROM_W-1:0]  rom_data_i,
    output logic [HP_W-1:0]   tone_hp_o,
    output logic              busy_o,
    output logic              melody_done_o
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NOTES - 1);
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DUR_W-1:0]  rem_q;
    logic [DUR_W-1:0]  saved_rem_q;
    logic [HP_W-1:0]   saved_hp_q;
    logic [HP_W-1:0]   tone_hp_q;
    logic              beep_ack_q;
    logic              done_q;
    logic              paused_q;
    logic              start_pend_q;

    logic              tick;
    logic              start_ok;
    logic              last_tick;
    logic [HP_W-1:0]   note_hp;
    logic [DUR_W-1:0]  note_dur;
    logic [HP_W-1:0]   beep_tone;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (hwclk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // A stop in the same cycle always beats a start.
    assign start_ok  = melody_start_i & ~melody_stop_i;
    assign last_tick = tick & (rem_q == DUR_ONE);
    assign note_hp   = rom_hp(rom_data_i);
    assign note_dur  = rom_dur(rom_data_i);
    assign beep_tone = (beep_ticks_i == '0) ? '0 : beep_hp_i;

    always_ff @(posedge hwclk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rom_addr_q   <= '0;
            rem_q        <= '0;
            saved_rem_q  <= '0;
            saved_hp_q   <= '0;
            tone_hp_q    <= '0;
            beep_ack_q   <= 1'b0;
            done_q       <= 1'b0;
            paused_q     <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            beep_ack_q <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (beep_req_i) begin
                        beep_ack_q <= 1'b1;
                        rem_q      <= beep_ticks_i;
                        tone_hp_q  <= beep_tone;
                        state_q    <= ST_BEEP;
                        if (start_ok) begin
                            start_pend_q <= 1'b1;
                        end
                    end else if (start_ok || start_pend_q) begin
                        idx_q        <= '0;
                        rom_addr_q   <= '0;
                        start_pend_q <= 1'b0;
                        state_q      <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    if (melody_stop_i) begin
                        tone_hp_q    <= '0;
                        paused_q     <= 1'b0;
                        start_pend_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (melody_stop_i) begin
                        tone_hp_q    <= '0;
                        paused_q     <= 1'b0;
                        start_pend_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (note_dur == '0) begin
                        tone_hp_q <= '0;
                        done_q    <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        rem_q     <= note_dur;
                        tone_hp_q <= note_hp;
                        state_q   <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (melody_stop_i) begin
                        tone_hp_q    <= '0;
                        paused_q     <= 1'b0;
                        start_pend_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (beep_req_i) begin
                        // The tick coinciding with the preemption is dropped;
                        // it stays within the one-tick phase tolerance.
                        beep_ack_q  <= 1'b1;
                        saved_rem_q <= rem_q;
                        saved_hp_q  <= tone_hp_q;
                        paused_q    <= 1'b1;
                        rem_q       <= beep_ticks_i;
                        tone_hp_q   <= beep_tone;
                        state_q     <= ST_BEEP;
                    end else if (last_tick) begin
                        if (idx_q == IDX_LAST) begin
                            tone_hp_q <= '0;
                            done_q    <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= ST_IDLE;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            rom_addr_q <= idx_q + 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end else if (tick) begin
                        rem_q <= rem_q - 1'b1;
                    end
                end

                ST_BEEP: begin
                    if (melody_stop_i) begin
                        paused_q     <= 1'b0;
                        start_pend_q <= 1'b0;
                    end else if (melody_start_i && !paused_q) begin
                        start_pend_q <= 1'b1;
                    end

                    if (rem_q == '0 || last_tick) begin
                        if (paused_q && !melody_stop_i) begin
                            tone_hp_q <= saved_hp_q;
                            rem_q     <= saved_rem_q;
                            paused_q  <= 1'b0;
                            state_q   <= ST_PLAY;
                        end else begin
                            tone_hp_q <= '0;
                            state_q   <= ST_IDLE;
                        end
                    end else if (tick) begin
                        rem_q <= rem_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign beep_ack_o    = beep_ack_q;
    assign rom_addr_o    = rom_addr_q;
    assign tone_hp_o     = tone_hp_q;
    assign melody_done_o = done_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with a 4-cycle tick and a small
// synchronous note ROM model.
module tb_tone_scheduler;

    localparam int TD = 4;

    logic        hwclk = 1'b0;
    logic        rst = 1'b1;
    logic        melody_start = 1'b0;
    logic        melody_stop = 1'b0;
    logic        beep_req = 1'b0;
    logic [15:0] beep_hp = '0;
    logic [15:0] beep_ticks = '0;
    logic        beep_ack;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic [15:0] tone_hp;
    logic        busy;
    logic        melody_done;

    logic [31:0] rom [32];

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] hp;
        logic [15:0] ticks;
        logic [15:0] exp_tone;
        int          lo;
        int          hi;
    } beep_vec_t;

    beep_vec_t vecs [5];

    always #5 hwclk = ~hwclk;

    always @(posedge hwclk) rom_data <= rom[rom_addr];

    always @(posedge hwclk) begin
        if (beep_ack) ack_cnt++;
        if (melody_done) done_cnt++;
    end

    tone_scheduler #(
        .TICK_DIV (TD),
        .NOTES    (32)
    ) dut (
        .hwclk_i        (hwclk),
        .rst_i          (rst),
        .melody_start_i (melody_start),
        .melody_stop_i  (melody_stop),
        .beep_req_i     (beep_req),
        .beep_hp_i      (beep_hp),
        .beep_ticks_i   (beep_ticks),
        .beep_ack_o     (beep_ack),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .tone_hp_o      (tone_hp),
        .busy_o         (busy),
        .melody_done_o  (melody_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic measure_tone(input logic [15:0] val, output int n);
        n = 0;
        while (tone_hp == val && n < 1000) begin
            n++;
            @(negedge hwclk);
        end
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge hwclk);
        end
    endtask

    task automatic wait_tone(input logic [15:0] val, input string name);
        int n;
        n = 0;
        while (tone_hp !== val && n < 200) begin
            n++;
            @(negedge hwclk);
        end
        check({name, "_reached"}, 32'(tone_hp == val), 32'd1);
    endtask

    // Pulse melody_start at a negedge; leaves the caller at the first PLAY cycle.
    task automatic start_melody(input logic [15:0] first_hp, input string tag);
        melody_start = 1'b1;
        @(negedge hwclk);
        melody_start = 1'b0;
        check({tag, "_fetch_busy"}, 32'(busy), 32'd1);
        check({tag, "_fetch_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_fetch_tone"}, 32'(tone_hp), 32'd0);
        @(negedge hwclk);
        check({tag, "_load_tone"}, 32'(tone_hp), 32'd0);
        @(negedge hwclk);
        check({tag, "_first_note"}, 32'(tone_hp), 32'(first_hp));
    endtask

    task automatic rom_default();
        for (int i = 0; i < 32; i++) rom[i] = 32'd0;
        rom[0] = {16'd100, 16'd3};
        rom[1] = {16'd200, 16'd2};
    endtask

    initial begin
        int n;
        int bad;
        int dbase;
        int abase;
        int seen_cnt;
        logic [31:0] seen;

        vecs[0] = '{hp: 16'd50,    ticks: 16'd1, exp_tone: 16'd50,    lo: 1,        hi: TD};
        vecs[1] = '{hp: 16'd7,     ticks: 16'd3, exp_tone: 16'd7,     lo: 2*TD + 1, hi: 3*TD};
        vecs[2] = '{hp: 16'hFFFF,  ticks: 16'd2, exp_tone: 16'hFFFF,  lo: TD + 1,   hi: 2*TD};
        vecs[3] = '{hp: 16'd33,    ticks: 16'd0, exp_tone: 16'd0,     lo: 1,        hi: 2};
        vecs[4] = '{hp: 16'd1,     ticks: 16'd1, exp_tone: 16'd1,     lo: 1,        hi: TD};

        rom_default();

        // Reset and idle
        cyc(3);
        rst = 1'b0;
        @(negedge hwclk);
        check("rst_tone", 32'(tone_hp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_ack", 32'(beep_ack), 32'd0);
        check("rst_done", 32'(melody_done), 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tone_hp != 0 || busy || beep_ack || melody_done) bad++;
            @(negedge hwclk);
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_ack_cnt", 32'(ack_cnt), 32'd0);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);

        // Plain melody
        dbase = done_cnt;
        start_melody(16'd100, "mel");
        measure_tone(16'd100, n);
        check_rng("mel_note1_len", n, 2*TD + 1 + 2, 3*TD + 2);
        check("mel_note2_hp", 32'(tone_hp), 32'd200);
        measure_tone(16'd200, n);
        check_rng("mel_note2_len", n, TD + 1 + 2, 2*TD + 2);
        check("mel_end_tone", 32'(tone_hp), 32'd0);
        check("mel_end_busy", 32'(busy), 32'd0);
        check("mel_end_done", 32'(melody_done), 32'd1);
        cyc(2);
        check("mel_done_once", 32'(done_cnt - dbase), 32'd1);

        // Beep preempting note 1 with two ticks left
        dbase = done_cnt;
        abase = ack_cnt;
        start_melody(16'd100, "pre");
        cyc(4);
        beep_req = 1'b1;
        beep_hp = 16'd50;
        beep_ticks = 16'd1;
        @(negedge hwclk);
        beep_req = 1'b0;
        check("pre_ack", 32'(beep_ack), 32'd1);
        check("pre_beep_tone", 32'(tone_hp), 32'd50);
        measure_tone(16'd50, n);
        check_rng("pre_beep_len", n, 1, TD);
        check("pre_resume_hp", 32'(tone_hp), 32'd100);
        measure_tone(16'd100, n);
        check_rng("pre_resume_len", n, TD + 1 + 2, 2*TD + 2);
        check("pre_note2_hp", 32'(tone_hp), 32'd200);
        check("pre_no_early_done", 32'(done_cnt - dbase), 32'd0);
        measure_tone(16'd200, n);
        check_rng("pre_note2_len", n, TD + 1 + 2, 2*TD + 2);
        check("pre_end_busy", 32'(busy), 32'd0);
        cyc(2);
        check("pre_done_once", 32'(done_cnt - dbase), 32'd1);
        check("pre_ack_once", 32'(ack_cnt - abase), 32'd1);

        // Stop during note 2, then simultaneous beep and start in IDLE
        dbase = done_cnt;
        start_melody(16'd100, "stp");
        wait_tone(16'd200, "stp_note2");
        cyc(2);
        melody_stop = 1'b1;
        @(negedge hwclk);
        melody_stop = 1'b0;
        check("stp_tone", 32'(tone_hp), 32'd0);
        check("stp_busy", 32'(busy), 32'd0);
        check("stp_done", 32'(melody_done), 32'd0);
        beep_req = 1'b1;
        beep_hp = 16'd77;
        beep_ticks = 16'd2;
        melody_start = 1'b1;
        @(negedge hwclk);
        beep_req = 1'b0;
        melody_start = 1'b0;
        check("both_ack", 32'(beep_ack), 32'd1);
        check("both_beep_tone", 32'(tone_hp), 32'd77);
        measure_tone(16'd77, n);
        check_rng("both_beep_len", n, TD + 1, 2*TD);
        measure_tone(16'd0, n);
        check("both_gap", 32'(n), 32'd3);
        check("both_melody_after", 32'(tone_hp), 32'd100);
        melody_stop = 1'b1;
        @(negedge hwclk);
        melody_stop = 1'b0;
        check("both_stop_tone", 32'(tone_hp), 32'd0);
        cyc(2);
        check("stp_no_done", 32'(done_cnt - dbase), 32'd0);

        // Beep table from IDLE
        for (int i = 0; i < 5; i++) begin
            beep_req = 1'b1;
            beep_hp = vecs[i].hp;
            beep_ticks = vecs[i].ticks;
            @(negedge hwclk);
            beep_req = 1'b0;
            check($sformatf("vec%0d_ack", i), 32'(beep_ack), 32'd1);
            check($sformatf("vec%0d_tone", i), 32'(tone_hp), 32'(vecs[i].exp_tone));
            measure_busy(n);
            check_rng($sformatf("vec%0d_len", i), n, vecs[i].lo, vecs[i].hi);
            check($sformatf("vec%0d_silent", i), 32'(tone_hp), 32'd0);
            check($sformatf("vec%0d_no_reack", i), 32'(beep_ack), 32'd0);
            cyc(1);
        end

        // ROM without an end marker
        for (int i = 0; i < 32; i++) rom[i] = {16'd10, 16'd1};
        dbase = done_cnt;
        seen = '0;
        start_melody(16'd10, "wrap");
        n = 0;
        while (busy && n < 1000) begin
            seen[rom_addr] = 1'b1;
            n++;
            @(negedge hwclk);
        end
        seen_cnt = $countones(seen);
        check("wrap_addrs_seen", 32'(seen_cnt), 32'd32);
        check("wrap_done_pulse", 32'(melody_done), 32'd1);
        check("wrap_tone", 32'(tone_hp), 32'd0);
        cyc(3);
        check("wrap_done_once", 32'(done_cnt - dbase), 32'd1);
        check("wrap_idle", 32'(busy), 32'd0);

        // Reset mid-beep with the request still held
        beep_req = 1'b1;
        beep_hp = 16'd55;
        beep_ticks = 16'd3;
        @(negedge hwclk);
        check("rb_ack", 32'(beep_ack), 32'd1);
        cyc(2);
        abase = ack_cnt;
        rst = 1'b1;
        @(negedge hwclk);
        check("rb_tone", 32'(tone_hp), 32'd0);
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_ack_low", 32'(beep_ack), 32'd0);
        check("rb_done_low", 32'(melody_done), 32'd0);
        check("rb_addr", 32'(rom_addr), 32'd0);
        cyc(1);
        rst = 1'b0;
        beep_req = 1'b0;
        cyc(3);
        check("rb_no_ack", 32'(ack_cnt - abase), 32'd0);

        // Reset mid-note
        rom_default();
        start_melody(16'd100, "rn");
        cyc(1);
        rst = 1'b1;
        @(negedge hwclk);
        rst = 1'b0;
        check("rn_tone", 32'(tone_hp), 32'd0);
        check("rn_busy", 32'(busy), 32'd0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
